// File: rtl/sha_seq_if.sv
// ----------------------------------------------------------------------------
// sha_seq_if
//   Bundles the signals between the SHA A/B test sequencer, the test trigger
//   logic and the two SHA engines.
//
//   Trigger side : run_start, num_runs, seed -> busy, run_done
//   Engine side  : msg_word, sha0_start, sha1_start -> sha0/1_done, sha0/1_digest
//   Readout side : pass_cnt, fail_cnt, timeout_cnt, last_lat0, last_lat1
//
//   slave  : the sequencer's view (drives msg_word, starts, status, tallies)
//   master : the environment's view (trigger logic plus both engines)
// ----------------------------------------------------------------------------
interface sha_seq_if #(
  parameter int CNT_W = 16
);
  logic             run_start;
  logic [15:0]      num_runs;
  logic [31:0]      seed;
  logic [31:0]      msg_word;
  logic             sha0_start;
  logic             sha1_start;
  logic             sha0_done;
  logic [255:0]     sha0_digest;
  logic             sha1_done;
  logic [255:0]     sha1_digest;
  logic             busy;
  logic             run_done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] timeout_cnt;
  logic [CNT_W-1:0] last_lat0;
  logic [CNT_W-1:0] last_lat1;

  modport slave (
    input  run_start, num_runs, seed,
    input  sha0_done, sha0_digest, sha1_done, sha1_digest,
    output msg_word, sha0_start, sha1_start, busy, run_done,
    output pass_cnt, fail_cnt, timeout_cnt, last_lat0, last_lat1
  );

  modport master (
    output run_start, num_runs, seed,
    output sha0_done, sha0_digest, sha1_done, sha1_digest,
    input  msg_word, sha0_start, sha1_start, busy, run_done,
    input  pass_cnt, fail_cnt, timeout_cnt, last_lat0, last_lat1
  );
endinterface

// File: rtl/sha_test_sequencer.sv
// ----------------------------------------------------------------------------
// sha_test_sequencer
//   Runs a batch of SHA256 A/B comparisons: launches both engines on the same
//   message word, waits for both digests (with a timeout), compares them,
//   records per-engine latency and keeps saturating pass/fail/timeout tallies.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset; aborts any batch in progress
//     bus  - sha_seq_if.slave (trigger inputs, engine handshakes, tallies)
// ----------------------------------------------------------------------------
module sha_test_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  sha_seq_if.slave   bus
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_COMPARE, S_GAP, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      msg_q, msg_d;
  logic [15:0]      num_runs_q, num_runs_d;
  logic [15:0]      run_idx_q, run_idx_d;
  logic             flag0_q, flag0_d, flag1_q, flag1_d;
  logic [255:0]     dig0_q, dig0_d, dig1_q, dig1_d;
  logic [CNT_W-1:0] lat0_q, lat0_d, lat1_q, lat1_d;
  logic [CNT_W-1:0] last_lat0_q, last_lat0_d, last_lat1_q, last_lat1_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic             zero_done_q, zero_done_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic start_ok, both_got, wait_last, gap_last, last_run;

  always_comb begin
    start_ok  = bus.run_start && (state_q == S_IDLE);
    // A strobe arriving this cycle counts as "done" for the exit decision.
    both_got  = (flag0_q | bus.sha0_done) & (flag1_q | bus.sha1_done);
    wait_last = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    gap_last  = (gap_q == GAP_W'(GAP_CYCLES - 1));
    last_run  = ((run_idx_q + 16'd1) == num_runs_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok && (bus.num_runs != 16'd0)) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT:    if (both_got) state_d = S_COMPARE;
                 else if (wait_last) state_d = S_GAP;
      S_COMPARE: state_d = S_GAP;
      S_GAP:     if (gap_last) state_d = last_run ? S_DONE : S_LAUNCH;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs (Moore, plus the zero-run acknowledge pulse)
  always_comb begin
    bus.sha0_start = (state_q == S_LAUNCH);
    bus.sha1_start = (state_q == S_LAUNCH);
    bus.busy       = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                     (state_q == S_COMPARE) || (state_q == S_GAP);
    bus.run_done   = (state_q == S_DONE) || zero_done_q;
    bus.msg_word    = msg_q;
    bus.pass_cnt    = pass_q;
    bus.fail_cnt    = fail_q;
    bus.timeout_cnt = tout_q;
    bus.last_lat0   = last_lat0_q;
    bus.last_lat1   = last_lat1_q;
  end

  // Datapath next-state
  always_comb begin
    msg_d       = msg_q;
    num_runs_d  = num_runs_q;
    run_idx_d   = run_idx_q;
    flag0_d     = flag0_q;
    flag1_d     = flag1_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    lat0_d      = lat0_q;
    lat1_d      = lat1_q;
    last_lat0_d = last_lat0_q;
    last_lat1_d = last_lat1_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    tout_d      = tout_q;
    wait_d      = wait_q;
    gap_d       = '0;
    zero_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          pass_d = '0;
          fail_d = '0;
          tout_d = '0;
          if (bus.num_runs != 16'd0) begin
            msg_d       = bus.seed;
            num_runs_d  = bus.num_runs;
            run_idx_d   = '0;
            last_lat0_d = '0;
            last_lat1_d = '0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        lat0_d  = '0;
        lat1_d  = '0;
        flag0_d = 1'b0;
        flag1_d = 1'b0;
        wait_d  = '0;
      end
      S_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        // Latency includes the cycle the strobe arrives in.
        if (!flag0_q) lat0_d = sat_inc(lat0_q);
        if (!flag1_q) lat1_d = sat_inc(lat1_q);
        if (bus.sha0_done && !flag0_q) begin
          flag0_d = 1'b1;
          dig0_d  = bus.sha0_digest;
        end
        if (bus.sha1_done && !flag1_q) begin
          flag1_d = 1'b1;
          dig1_d  = bus.sha1_digest;
        end
        if (!both_got && wait_last) tout_d = sat_inc(tout_q);
      end
      S_COMPARE: begin
        if (dig0_q == dig1_q) pass_d = sat_inc(pass_q);
        else                  fail_d = sat_inc(fail_q);
        last_lat0_d = lat0_q;
        last_lat1_d = lat1_q;
      end
      S_GAP: begin
        if (gap_last) begin
          msg_d     = msg_q + 32'd1;
          run_idx_d = run_idx_q + 16'd1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q       <= '0;
      num_runs_q  <= '0;
      run_idx_q   <= '0;
      flag0_q     <= 1'b0;
      flag1_q     <= 1'b0;
      dig0_q      <= '0;
      dig1_q      <= '0;
      lat0_q      <= '0;
      lat1_q      <= '0;
      last_lat0_q <= '0;
      last_lat1_q <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      tout_q      <= '0;
      wait_q      <= '0;
      gap_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      msg_q       <= msg_d;
      num_runs_q  <= num_runs_d;
      run_idx_q   <= run_idx_d;
      flag0_q     <= flag0_d;
      flag1_q     <= flag1_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      lat0_q      <= lat0_d;
      lat1_q      <= lat1_d;
      last_lat0_q <= last_lat0_d;
      last_lat1_q <= last_lat1_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tout_q      <= tout_d;
      wait_q      <= wait_d;
      gap_q       <= gap_d;
      zero_done_q <= zero_done_d;
    end
  end

endmodule

// File: tb/tb_sha_test_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sha_test_sequencer
//   Directed bench for sha_test_sequencer: a small two-engine responder
//   model (configurable latency, digest corruption, duplicate strobes) plus a
//   linear sequence of batches with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_sha_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha_seq_if #(.CNT_W(16)) bus();

  sha_test_sequencer #(
    .TIMEOUT_CYCLES(4096),
    .GAP_CYCLES(16),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Engine responder configuration (written by the stimulus block only)
  int lat0_cfg = 64;
  int lat1_cfg = 64;
  int dup0_at  = 0;
  int flip_run = -1;

  // Engine responder state (written by the model only)
  int          cnt0, cnt1;
  bit          armed0, armed1;
  logic [31:0] m0, m1;
  int          starts0 = 0;
  int          starts1 = 0;
  logic [31:0] msg_log[$];

  function automatic logic [255:0] mk_digest(input logic [31:0] m);
    return {8{m ^ 32'hC0DE_0000}};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      armed0 = 1'b0;
      armed1 = 1'b0;
      bus.sha0_done   = 1'b0;
      bus.sha1_done   = 1'b0;
      bus.sha0_digest = '0;
      bus.sha1_digest = '0;
    end else begin
      bus.sha0_done = 1'b0;
      bus.sha1_done = 1'b0;
      if (armed0) begin
        cnt0++;
        if (cnt0 == lat0_cfg) begin
          bus.sha0_done   = 1'b1;
          bus.sha0_digest = mk_digest(m0);
        end else if (dup0_at != 0 && cnt0 == dup0_at) begin
          bus.sha0_done   = 1'b1;
          bus.sha0_digest = ~mk_digest(m0);
        end
      end
      if (armed1) begin
        cnt1++;
        if (cnt1 == lat1_cfg) begin
          bus.sha1_done   = 1'b1;
          bus.sha1_digest = mk_digest(m1);
          if (starts1 == flip_run) bus.sha1_digest[0] = ~bus.sha1_digest[0];
        end
      end
      if (bus.sha0_start) begin
        armed0 = 1'b1;
        cnt0   = 0;
        m0     = bus.msg_word;
        starts0++;
        msg_log.push_back(bus.msg_word);
      end
      if (bus.sha1_start) begin
        armed1 = 1'b1;
        cnt1   = 0;
        m1     = bus.msg_word;
        starts1++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse run_start; returns at the negedge of the LAUNCH cycle (or of the
  // cycle after acceptance for num_runs=0). t0 is the run_start cycle.
  task automatic launch(input logic [15:0] n, input logic [31:0] s, output int t0);
    @(negedge clk);
    bus.run_start = 1'b1;
    bus.num_runs  = n;
    bus.seed      = s;
    t0 = cyc;
    @(negedge clk);
    bus.run_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.run_done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("run_done_seen", 64'(at >= 0), 64'd1);
  endtask

  int t0, at, b0, b1;

  initial begin
    rst = 1'b1;
    bus.run_start = 1'b0;
    bus.num_runs  = '0;
    bus.seed      = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_msg_word", bus.msg_word, 64'h0);
    check("rst_busy", bus.busy, 64'h0);
    check("rst_run_done", bus.run_done, 64'h0);
    check("rst_start0", bus.sha0_start, 64'h0);
    check("rst_pass", bus.pass_cnt, 64'h0);
    check("rst_lat0", bus.last_lat0, 64'h0);
    rst = 1'b0;

    // 1: three equal runs, both engines at 64 cycles; a run_start mid-batch is ignored
    lat0_cfg = 64; lat1_cfg = 64; dup0_at = 0; flip_run = -1;
    b0 = starts0; b1 = starts1;
    launch(16'd3, 32'h10, t0);
    check("t1_busy_launch", bus.busy, 64'h1);
    check("t1_start0_launch", bus.sha0_start, 64'h1);
    repeat (20) @(negedge clk);
    bus.run_start = 1'b1; bus.num_runs = 16'd0;
    @(negedge clk);
    bus.run_start = 1'b0;
    @(negedge clk);
    check("t1_ignored_busy", bus.busy, 64'h1);
    check("t1_ignored_done", bus.run_done, 64'h0);
    wait_done(2000, at);
    check("t1_busy_at_done", bus.busy, 64'h0);
    check("t1_pass", bus.pass_cnt, 64'd3);
    check("t1_fail", bus.fail_cnt, 64'd0);
    check("t1_lat0", bus.last_lat0, 64'd64);
    check("t1_lat1", bus.last_lat1, 64'd64);
    check("t1_msg_word", bus.msg_word, 64'h13);
    check("t1_starts0", 64'(starts0 - b0), 64'd3);
    check("t1_starts1", 64'(starts1 - b1), 64'd3);
    @(negedge clk);
    check("t1_done_one_cycle", bus.run_done, 64'h0);

    // 2: engine 1 digest corrupted on run 2 of 4
    lat0_cfg = 40; lat1_cfg = 50;
    flip_run = starts1 + 2;
    launch(16'd4, 32'h100, t0);
    wait_done(2000, at);
    check("t2_pass", bus.pass_cnt, 64'd3);
    check("t2_fail", bus.fail_cnt, 64'd1);
    check("t2_timeout", bus.timeout_cnt, 64'd0);
    check("t2_lat0", bus.last_lat0, 64'd40);
    check("t2_lat1", bus.last_lat1, 64'd50);
    flip_run = -1;

    // 3: engine 1 silent -> two timeouts, run_done ~2*(1+4096+16) cycles later
    lat0_cfg = 64; lat1_cfg = 0;
    launch(16'd2, 32'h200, t0);
    wait_done(20000, at);
    check("t3_timeout", bus.timeout_cnt, 64'd2);
    check("t3_pass", bus.pass_cnt, 64'd0);
    check("t3_done_time", 64'((at - t0 >= 8225) && (at - t0 <= 8227)), 64'd1);
    check("t3_lat0_kept", bus.last_lat0, 64'd0);
    check("t3_lat1_kept", bus.last_lat1, 64'd0);

    // 4: simultaneous strobes, duplicate sha0_done 5 cycles later
    lat0_cfg = 30; lat1_cfg = 30; dup0_at = 35;
    launch(16'd1, 32'h300, t0);
    wait_done(2000, at);
    check("t4_pass", bus.pass_cnt, 64'd1);
    check("t4_fail", bus.fail_cnt, 64'd0);
    check("t4_lat0", bus.last_lat0, 64'd30);

    // 5: duplicate sha0_done while still waiting for engine 1
    lat0_cfg = 10; lat1_cfg = 20; dup0_at = 15;
    launch(16'd1, 32'h400, t0);
    wait_done(2000, at);
    check("t5_pass", bus.pass_cnt, 64'd1);
    check("t5_fail", bus.fail_cnt, 64'd0);
    check("t5_lat0", bus.last_lat0, 64'd10);
    check("t5_lat1", bus.last_lat1, 64'd20);
    dup0_at = 0;

    // 6: reset during WAIT of run 2, then a wrapping batch
    lat0_cfg = 64; lat1_cfg = 64;
    b0 = starts0;
    launch(16'd3, 32'h55, t0);
    for (int i = 0; i < 1000 && (starts0 - b0) < 2; i++) @(negedge clk);
    check("t6_second_start", 64'(starts0 - b0), 64'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", bus.busy, 64'h0);
    check("t6_rst_msg", bus.msg_word, 64'h0);
    check("t6_rst_pass", bus.pass_cnt, 64'h0);
    check("t6_rst_lat0", bus.last_lat0, 64'h0);
    check("t6_rst_start", bus.sha0_start, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_start", bus.sha0_start, 64'h0);
    lat0_cfg = 8; lat1_cfg = 8;
    b0 = starts0;
    launch(16'd2, 32'hFFFF_FFFF, t0);
    wait_done(2000, at);
    check("t6_msg_run1", 64'(msg_log[b0]), 64'hFFFF_FFFF);
    check("t6_msg_run2", 64'(msg_log[b0 + 1]), 64'h0);
    check("t6_msg_end", bus.msg_word, 64'h1);
    check("t6_pass", bus.pass_cnt, 64'd2);

    // 7: num_runs = 0 -> run_done next cycle, tallies cleared, no starts
    b0 = starts0;
    launch(16'd0, 32'h999, t0);
    check("t7_run_done", bus.run_done, 64'h1);
    check("t7_busy", bus.busy, 64'h0);
    check("t7_pass_cleared", bus.pass_cnt, 64'h0);
    @(negedge clk);
    check("t7_done_pulse", bus.run_done, 64'h0);
    check("t7_no_starts", 64'(starts0 - b0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
